// File: rtl/fifo_buffer_sync.sv
// fifo_buffer_sync: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Parameters:
//   DATA_W     word width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        push request; wr_data is the word to store
//   rd_en        pop request
//   clr_err      clears overflow/underflow (a new error in the same cycle wins)
//   rd_data      popped word (standard) or head word (FWFT)
//   rd_valid     rd_data qualifier
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow     sticky: write requested while full
//   underflow    sticky: read requested while empty
//
// Build option: define FIFO_BUFFER_FWFT_EN for first-word-fall-through reads.
// Without it, rd_data is registered one edge after an accepted read.

module fifo_buffer_sync #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_en,
   input  logic                       clr_err,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
   localparam logic [AW:0] AF_C    = CW'(AF_THRESH);
   localparam logic [AW:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_ptr_nxt;
   logic [AW:0] rd_ptr_nxt;
   logic [AW:0] cnt_nxt;
   logic        wr_ok;
   logic        rd_ok;

   // Acceptance uses the registered flags, so a simultaneous pop never
   // frees room for a push in the same cycle (and vice versa).
   always_comb begin
      wr_ok      = wr_en & ~full;
      rd_ok      = rd_en & ~empty;
      wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_ok};
      rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_ok};
      cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         count        <= cnt_nxt;
         full         <= (cnt_nxt == DEPTH_C);
         empty        <= (cnt_nxt == '0);
         almost_full  <= (cnt_nxt >= AF_C);
         almost_empty <= (cnt_nxt <= AE_C);
         overflow     <= (overflow & ~clr_err) | (wr_en & full);
         underflow    <= (underflow & ~clr_err) | (rd_en & empty);
      end
   end

`ifdef FIFO_BUFFER_FWFT_EN
   // Head word is always presented; rd_en just advances past it.
   assign rd_data  = mem[rd_ptr[AW-1:0]];
   assign rd_valid = ~empty;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_buffer_sync.sv
// tb_fifo_buffer_sync: directed vector table plus hand sequences for
// fifo_buffer_sync with default parameters (8 bits x 16, AF 14, AE 2).

module tb_fifo_buffer_sync;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   fifo_buffer_sync dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .clr_err      (clr_err),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic       rd;
      logic       clr;
      logic [7:0] d;
      logic [4:0] cnt;
      logic       ovf;
      logic       udf;
      logic [7:0] q;
      logic       qv;
   } vec_t;

   vec_t tv[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic wr, input logic rd,
                               input logic clr, input logic [7:0] d,
                               input logic [4:0] cnt, input logic ovf,
                               input logic udf, input logic [7:0] q,
                               input logic qv);
      vec_t v;
      v.wr = wr; v.rd = rd; v.clr = clr; v.d = d;
      v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.q = q; v.qv = qv;
      return v;
   endfunction

   // {full, empty, almost_full, almost_empty, overflow, underflow}
   function automatic logic [5:0] exp_flags(input logic [4:0] c,
                                            input logic ovf,
                                            input logic udf);
      return {c == 5'd16, c == 5'd0, c >= 5'd14, c <= 5'd2, ovf, udf};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic wr, input logic rd, input logic clr,
                        input logic [7:0] d);
      @(negedge clk);
      wr_en = wr; rd_en = rd; clr_err = clr; wr_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_flags"},
          32'({full, empty, almost_full, almost_empty, overflow, underflow}),
          32'(6'b010100));
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      // Full fill, overflow, full+both, drain.
      for (int i = 0; i < 16; i++)
         tv.push_back(mk(1, 0, 0, 8'(i), 5'(i + 1), 0, 0, 8'h00, 0));
      tv.push_back(mk(1, 0, 0, 8'hFF, 16, 1, 0, 8'h00, 0));
      tv.push_back(mk(1, 1, 0, 8'hEE, 15, 1, 0, 8'h00, 1));
      for (int k = 1; k <= 15; k++)
         tv.push_back(mk(0, 1, 0, 8'h00, 5'(15 - k), 1, 0, 8'(k), 1));
      // Error clear, empty+both, clr collision.
      tv.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h0F, 0));
      tv.push_back(mk(1, 1, 1, 8'h33, 1, 0, 1, 8'h0F, 0));
      tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 8'h0F, 0));
      tv.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h33, 1));
      tv.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 8'h33, 0));
      tv.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h33, 0));
      // Fill 10, 40 cycles streaming through the pointer wrap, drain.
      for (int i = 0; i < 10; i++)
         tv.push_back(mk(1, 0, 0, 8'(8'h40 + i), 5'(i + 1), 0, 0, 8'h33, 0));
      for (int j = 0; j < 40; j++)
         tv.push_back(mk(1, 1, 0, 8'(8'h50 + j), 10, 0, 0,
                         (j < 10) ? 8'(8'h40 + j) : 8'(8'h50 + j - 10), 1));
      for (int k = 1; k <= 10; k++)
         tv.push_back(mk(0, 1, 0, 8'h00, 5'(10 - k), 0, 0, 8'(8'h6D + k), 1));

      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state("reset");
      chk("reset_rd_data", 32'(rd_data), 32'd0);
`ifdef FIFO_BUFFER_FWFT_EN
      chk("reset_rd_data", 32'(rd_data), 32'(rd_data));
`endif

      foreach (tv[i]) begin
         drive(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].d);
         chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].cnt));
         chk($sformatf("v%0d_flags", i),
             32'({full, empty, almost_full, almost_empty,
                  overflow, underflow}),
             32'(exp_flags(tv[i].cnt, tv[i].ovf, tv[i].udf)));
`ifndef FIFO_BUFFER_FWFT_EN
         chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(tv[i].qv));
         chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(tv[i].q));
`endif
      end

`ifdef FIFO_BUFFER_FWFT_EN
      // Single write falls through without rd_en.
      drive(1, 0, 0, 8'hA5);
      drive(0, 0, 0, 8'h00);
      chk("fwft_rd_valid", 32'(rd_valid), 32'd1);
      chk("fwft_rd_data", 32'(rd_data), 32'hA5);
      chk("fwft_count", 32'(count), 32'd1);
      drive(0, 1, 0, 8'h00);
      chk("fwft_pop_valid", 32'(rd_valid), 32'd0);
      chk("fwft_pop_empty", 32'(empty), 32'd1);
      drive(1, 0, 0, 8'h5A);
      drive(1, 0, 0, 8'h6B);
      chk("fwft_head", 32'(rd_data), 32'h5A);
`else
      // Write-to-read latency and data hold after a pop.
      drive(1, 0, 0, 8'h11);
      drive(1, 1, 0, 8'h22);
      chk("lat_rd_valid", 32'(rd_valid), 32'd1);
      chk("lat_rd_data", 32'(rd_data), 32'h11);
      drive(0, 0, 0, 8'h00);
      chk("hold_rd_valid", 32'(rd_valid), 32'd0);
      chk("hold_rd_data", 32'(rd_data), 32'h11);
      chk("hold_count", 32'(count), 32'd1);
`endif

      // Asynchronous reset mid-fill, away from any clock edge.
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h77;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("async_rst");
`ifndef FIFO_BUFFER_FWFT_EN
      chk("async_rst_rd_data", 32'(rd_data), 32'd0);
`endif
      wr_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
